// File: rtl/match_controller.sv
// Best-of-N round/match sequencer for the fighting game: intro countdown,
// round clock, result hold and match decision.
// Ports: clk, reset (sync, active-high), start_btn (level), finish[1:0],
//   p1_health[3:0], p2_health[3:0] in; game_rst_l, phase[2:0],
//   timer_sec[6:0], round_num[2:0], p1_wins[1:0], p2_wins[1:0],
//   round_result[1:0], match_winner[1:0] out. All outputs registered.
module match_controller #(
  parameter int TICKS_PER_SEC  = 100_000_000,
  parameter int INTRO_SECONDS  = 3,
  parameter int ROUND_SECONDS  = 99,
  parameter int RESULT_SECONDS = 3,
  parameter int WINS_NEEDED    = 2,
  parameter int MAX_ROUNDS     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [1:0] finish,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic       game_rst_l,
  output logic [2:0] phase,
  output logic [6:0] timer_sec,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] round_result,
  output logic [1:0] match_winner
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO      = 3'd1,
    FIGHT      = 3'd2,
    ROUND_END  = 3'd3,
    MATCH_OVER = 3'd4
  } phase_t;

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] INTRO_T  = 7'(INTRO_SECONDS);
  localparam logic [6:0] ROUND_T  = 7'(ROUND_SECONDS);
  localparam logic [6:0] RESULT_T = 7'(RESULT_SECONDS);
  localparam logic [1:0] WN = 2'(WINS_NEEDED);
  localparam logic [2:0] MR = 3'(MAX_ROUNDS);

  phase_t        state;
  logic [PW-1:0] presc;
  logic          start_q;
  logic          tick;
  logic          last_sec;
  logic          start_rise;
  logic          ko;
  logic [1:0]    res;

  assign phase      = state;
  assign tick       = (presc == PMAX);
  assign last_sec   = tick && (timer_sec == 7'd1);
  assign start_rise = start_btn && !start_q;
  assign ko         = (finish == 2'b01) || (finish == 2'b11);

  // A knockout always outranks the clock; on timeout health decides.
  always_comb begin
    res = 2'b11;
    if (finish == 2'b01)
      res = 2'b01;
    else if (finish == 2'b11)
      res = 2'b10;
    else if (p1_health > p2_health)
      res = 2'b01;
    else if (p2_health > p1_health)
      res = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      start_q      <= 1'b1;
      game_rst_l   <= 1'b0;
      timer_sec    <= '0;
      round_num    <= '0;
      p1_wins      <= '0;
      p2_wins      <= '0;
      round_result <= '0;
      match_winner <= '0;
    end else begin
      start_q <= start_btn;
      presc   <= tick ? '0 : presc + 1'b1;
      unique case (state)
        IDLE, MATCH_OVER: begin
          if (start_rise) begin
            state        <= INTRO;
            presc        <= '0;
            round_num    <= 3'd1;
            p1_wins      <= '0;
            p2_wins      <= '0;
            round_result <= '0;
            match_winner <= '0;
            timer_sec    <= INTRO_T;
            game_rst_l   <= 1'b0;
          end
        end
        INTRO: begin
          if (last_sec) begin
            state      <= FIGHT;
            presc      <= '0;
            timer_sec  <= ROUND_T;
            game_rst_l <= 1'b1;
          end else if (tick) begin
            timer_sec <= timer_sec - 1'b1;
          end
        end
        FIGHT: begin
          if (ko || last_sec) begin
            state        <= ROUND_END;
            presc        <= '0;
            round_result <= res;
            timer_sec    <= RESULT_T;
            if (res == 2'b01 && p1_wins != WN)
              p1_wins <= p1_wins + 1'b1;
            if (res == 2'b10 && p2_wins != WN)
              p2_wins <= p2_wins + 1'b1;
          end else if (tick) begin
            timer_sec <= timer_sec - 1'b1;
          end
        end
        ROUND_END: begin
          if (last_sec) begin
            presc <= '0;
            if (p1_wins == WN || p2_wins == WN) begin
              state        <= MATCH_OVER;
              timer_sec    <= '0;
              match_winner <= (p1_wins == WN) ? 2'b01 : 2'b10;
            end else if (round_num == MR) begin
              state     <= MATCH_OVER;
              timer_sec <= '0;
              if (p1_wins > p2_wins)
                match_winner <= 2'b01;
              else if (p2_wins > p1_wins)
                match_winner <= 2'b10;
              else
                match_winner <= 2'b11;
            end else begin
              state        <= INTRO;
              round_num    <= round_num + 1'b1;
              round_result <= '0;
              game_rst_l   <= 1'b0;
              timer_sec    <= INTRO_T;
            end
          end else if (tick) begin
            timer_sec <= timer_sec - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller with a one-second tick of
// four clocks; a match-level model predicts every round and match result.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0;
  logic [1:0] finish = 2'b00;
  logic [3:0] p1_health = 4'd0;
  logic [3:0] p2_health = 4'd0;
  logic       game_rst_l;
  logic [2:0] phase;
  logic [6:0] timer_sec;
  logic [2:0] round_num;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [1:0] round_result;
  logic [1:0] match_winner;

  int checks = 0;
  int errors = 0;

  // match-level model
  int m_round;
  int m_p1;
  int m_p2;

  localparam int TPS = 4;
  localparam int WN  = 2;
  localparam int MR  = 5;
  localparam int INTRO_CYC  = 3 * TPS;
  localparam int ROUND_CYC  = 99 * TPS;
  localparam int RESULT_CYC = 3 * TPS;

  match_controller #(
    .TICKS_PER_SEC(TPS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_btn(start_btn),
    .finish(finish),
    .p1_health(p1_health),
    .p2_health(p2_health),
    .game_rst_l(game_rst_l),
    .phase(phase),
    .timer_sec(timer_sec),
    .round_num(round_num),
    .p1_wins(p1_wins),
    .p2_wins(p2_wins),
    .round_result(round_result),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
  endtask

  task automatic model_start();
    m_round = 1;
    m_p1 = 0;
    m_p2 = 0;
  endtask

  // mode 0: P1 knockout, 1: P2 knockout, 2: timeout
  function automatic int outcome(int mode, int h1, int h2);
    if (mode == 0) return 1;
    if (mode == 1) return 2;
    if (h1 > h2) return 1;
    if (h2 > h1) return 2;
    return 3;
  endfunction

  // Plays one round starting right after entry to INTRO.
  task automatic play_round(input int mode, input int h1,
                            input int h2, input int dly);
    int r;
    int ew;
    int ep;
    step(INTRO_CYC);
    checks++;
    if (phase !== 3'd2 || timer_sec !== 7'd99 || game_rst_l !== 1'b1) begin
      errors++;
      $display("FAIL fight_entry phase=%0d timer=%0d grst=%0b",
               phase, timer_sec, game_rst_l);
    end
    p1_health = 4'(h1);
    p2_health = 4'(h2);
    if (mode == 2) begin
      finish = 2'b00;
      step(ROUND_CYC);
    end else begin
      finish = 2'b10;
      step(dly);
      if (dly == ROUND_CYC - 1) begin
        checks++;
        if (phase !== 3'd2 || timer_sec !== 7'd1) begin
          errors++;
          $display("FAIL last_sec phase=%0d timer=%0d exp 2/1",
                   phase, timer_sec);
        end
      end
      finish = (mode == 0) ? 2'b01 : 2'b11;
      step(1);
    end
    finish = 2'b00;
    r = outcome(mode, h1, h2);
    if (r == 1 && m_p1 < WN) m_p1++;
    if (r == 2 && m_p2 < WN) m_p2++;
    checks++;
    if (phase !== 3'd3 || round_result !== 2'(r) ||
        p1_wins !== 2'(m_p1) || p2_wins !== 2'(m_p2) ||
        timer_sec !== 7'd3) begin
      errors++;
      $display("FAIL round_end ph=%0d rr=%0d w=%0d/%0d t=%0d exp rr=%0d w=%0d/%0d",
               phase, round_result, p1_wins, p2_wins, timer_sec,
               r, m_p1, m_p2);
    end
    // result hold ignores finish, health and start
    finish = 2'($urandom_range(0, 3));
    p1_health = 4'($urandom);
    start_btn = 1'b1;
    step(RESULT_CYC / 2);
    start_btn = 1'b0;
    step(RESULT_CYC - RESULT_CYC / 2);
    finish = 2'b00;
    ew = 0;
    ep = 1;
    if (m_p1 == WN) begin
      ep = 4; ew = 1;
    end else if (m_p2 == WN) begin
      ep = 4; ew = 2;
    end else if (m_round == MR) begin
      ep = 4;
      ew = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
    end else begin
      m_round++;
    end
    checks++;
    if (ep == 4) begin
      if (phase !== 3'd4 || match_winner !== 2'(ew) ||
          timer_sec !== 7'd0 || game_rst_l !== 1'b1) begin
        errors++;
        $display("FAIL match_over ph=%0d mw=%0d t=%0d g=%0b exp mw=%0d",
                 phase, match_winner, timer_sec, game_rst_l, ew);
      end
    end else begin
      if (phase !== 3'd1 || round_num !== 3'(m_round) ||
          round_result !== 2'd0 || timer_sec !== 7'd3 ||
          game_rst_l !== 1'b0) begin
        errors++;
        $display("FAIL next_round ph=%0d rn=%0d rr=%0d t=%0d g=%0b exp rn=%0d",
                 phase, round_num, round_result, timer_sec,
                 game_rst_l, m_round);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++;
    if (phase !== 3'd0 || game_rst_l !== 1'b0 || timer_sec !== 7'd0 ||
        round_num !== 3'd0 || p1_wins !== 2'd0 || p2_wins !== 2'd0 ||
        round_result !== 2'd0 || match_winner !== 2'd0) begin
      errors++;
      $display("FAIL reset ph=%0d g=%0b t=%0d rn=%0d mw=%0d exp all 0",
               phase, game_rst_l, timer_sec, round_num, match_winner);
    end
    reset = 1'b0;
    step(3);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold phase=%0d exp 0", phase);
    end
  endtask

  task automatic test_intro();
    press_start();
    model_start();
    checks++;
    if (phase !== 3'd1 || round_num !== 3'd1 || timer_sec !== 7'd3 ||
        game_rst_l !== 1'b0) begin
      errors++;
      $display("FAIL intro ph=%0d rn=%0d t=%0d g=%0b exp 1/1/3/0",
               phase, round_num, timer_sec, game_rst_l);
    end
    step(INTRO_CYC - 1);
    checks++;
    if (phase !== 3'd1 || timer_sec !== 7'd1) begin
      errors++;
      $display("FAIL intro_last ph=%0d t=%0d exp 1/1", phase, timer_sec);
    end
    step(1);
    checks++;
    if (phase !== 3'd2 || timer_sec !== 7'd99 || game_rst_l !== 1'b1) begin
      errors++;
      $display("FAIL fight ph=%0d t=%0d g=%0b exp 2/99/1",
               phase, timer_sec, game_rst_l);
    end
  endtask

  task automatic test_finish_round();
    finish = 2'b01;
    step(1);
    finish = 2'b00;
    checks++;
    if (phase !== 3'd3 || round_result !== 2'b01 || p1_wins !== 2'd1) begin
      errors++;
      $display("FAIL ko_p1 ph=%0d rr=%0d w1=%0d exp 3/1/1",
               phase, round_result, p1_wins);
    end
    step(RESULT_CYC);
    m_round = 2;
    m_p1 = 1;
    checks++;
    if (phase !== 3'd1 || round_num !== 3'd2) begin
      errors++;
      $display("FAIL round2 ph=%0d rn=%0d exp 1/2", phase, round_num);
    end
  endtask

  task automatic test_match_win();
    play_round(0, 3, 8, $urandom_range(0, 40));
    press_start();
    model_start();
    checks++;
    if (phase !== 3'd1 || round_num !== 3'd1 || p1_wins !== 2'd0 ||
        p2_wins !== 2'd0 || match_winner !== 2'd0) begin
      errors++;
      $display("FAIL restart ph=%0d rn=%0d w=%0d/%0d mw=%0d",
               phase, round_num, p1_wins, p2_wins, match_winner);
    end
  endtask

  task automatic test_timeouts();
    int h;
    play_round(2, 7, 9, 0);
    h = $urandom_range(0, 15);
    play_round(2, 5, 5, 0);
    play_round(2, h, h, 0);
  endtask

  task automatic test_finish_vs_timeout();
    play_round(1, 9, 2, ROUND_CYC - 1);
  endtask

  task automatic test_draws();
    int h;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    press_start();
    model_start();
    for (int i = 0; i < MR; i++) begin
      h = $urandom_range(0, 15);
      play_round(2, h, h, 0);
    end
    checks++;
    if (match_winner !== 2'b11 || round_num !== 3'd5) begin
      errors++;
      $display("FAIL five_draws mw=%0d rn=%0d exp 3/5",
               match_winner, round_num);
    end
  endtask

  task automatic test_random_matches();
    int mode;
    for (int m = 0; m < 3; m++) begin
      press_start();
      model_start();
      while (phase == 3'd1) begin
        mode = ($urandom_range(0, 3) == 0) ? 2 : $urandom_range(0, 1);
        play_round(mode, $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 60));
      end
    end
  endtask

  task automatic test_mid_reset();
    press_start();
    step(INTRO_CYC);
    finish = 2'b11;
    step(1);
    finish = 2'b00;
    step(RESULT_CYC + INTRO_CYC);
    reset = 1'b1;
    step(1);
    checks++;
    if (phase !== 3'd0 || game_rst_l !== 1'b0 || p1_wins !== 2'd0 ||
        p2_wins !== 2'd0 || round_num !== 3'd0 || timer_sec !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset ph=%0d g=%0b w=%0d/%0d rn=%0d t=%0d",
               phase, game_rst_l, p1_wins, p2_wins, round_num, timer_sec);
    end
    start_btn = 1'b1;
    step(1);
    reset = 1'b0;
    step(8);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL held_start phase=%0d exp 0", phase);
    end
    start_btn = 1'b0;
    step(2);
    press_start();
    checks++;
    if (phase !== 3'd1 || round_num !== 3'd1) begin
      errors++;
      $display("FAIL repress ph=%0d rn=%0d exp 1/1", phase, round_num);
    end
  endtask

  initial begin
    test_reset();
    test_intro();
    test_finish_round();
    test_match_win();
    test_timeouts();
    test_finish_vs_timeout();
    test_draws();
    test_random_matches();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer that sits directly downstream of the core game block.
- Consumes the game block's finish code and both health values, and runs a best-of-N match with an intro countdown, a round clock and a result hold.
- Drives the game block's active-low reset so every round restarts with full health and starting positions.
- Exports phase, timer and score for the VGA overlay.

Parameters:
- TICKS_PER_SEC, 100_000_000: clk cycles per one-second tick.
- INTRO_SECONDS, 3: pre-round countdown length.
- ROUND_SECONDS, 99: round clock start value; max 127.
- RESULT_SECONDS, 3: hold time after a round ends.
- WINS_NEEDED, 2: round wins that take the match; max 3.
- MAX_ROUNDS, 5: round cap when rounds end in draws; max 7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start_btn  in  1  level input from the board; rising edge is detected internally.
- finish  in  2  from the game block: 00 running, 01 P1 won, 11 P2 won; 10 is ignored.
- p1_health  in  4  from the game block.
- p2_health  in  4  from the game block.
- game_rst_l  out  1  to the game block's reset; low holds the game in reset.
- phase  out  3  0 IDLE, 1 INTRO, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER.
- timer_sec  out  7  seconds remaining in the current phase.
- round_num  out  3  current round, 1-based; 0 in IDLE.
- p1_wins  out  2  round wins for P1.
- p2_wins  out  2  round wins for P2.
- round_result  out  2  00 none, 01 P1, 10 P2, 11 draw.
- match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- All outputs are registered.
- Reset, from any state, takes effect on the next edge. After reset:
  - phase=IDLE, game_rst_l=0.
  - timer_sec, round_num, both win counts, round_result and match_winner are all 0.
  - The prescaler is 0.
  - The start edge register resets to 1, so a button held through reset release does not start a match.
- Second tick:
  - sec_tick is a 1-cycle pulse when the prescaler reaches TICKS_PER_SEC-1; the prescaler then wraps to 0.
  - The prescaler clears on every phase transition, so each phase gets full seconds.
- IDLE: on a start rising edge -> INTRO. Set round_num=1, clear both win counts and match_winner, set timer_sec=INTRO_SECONDS.
- INTRO:
  - game_rst_l=0.
  - Decrement timer_sec on each tick.
  - A tick while timer_sec==1 -> FIGHT, with timer_sec=ROUND_SECONDS and game_rst_l=1 registered on the same edge.
- FIGHT:
  - game_rst_l=1.
  - finish==01 ends the round for P1; finish==11 ends it for P2.
  - Otherwise each tick decrements timer_sec. A tick while timer_sec==1 is a timeout:
    - The higher health wins the round.
    - Equal health is a draw.
  - If finish is nonzero and a timeout occurs in the same cycle, finish wins.
  - On round end:
    - Latch round_result.
    - Increment the winner's count, saturating at WINS_NEEDED; a draw increments nothing.
    - Go to ROUND_END with timer_sec=RESULT_SECONDS.
- ROUND_END:
  - game_rst_l stays 1 so the final scene stays displayed.
  - finish and health changes are ignored.
  - A tick while timer_sec==1 is expiry:
    - If either count equals WINS_NEEDED -> MATCH_OVER; match_winner is that player.
    - Else if round_num==MAX_ROUNDS -> MATCH_OVER; match_winner is the player with more wins, or 11 if equal.
    - Else -> INTRO with round_num+1, round_result=00, game_rst_l=0 and timer_sec=INTRO_SECONDS.
- MATCH_OVER:
  - Hold all outputs; timer_sec=0, game_rst_l=1.
  - A start rising edge starts a new match exactly as from IDLE.
- Start edges in INTRO, FIGHT and ROUND_END are ignored.
- Timer never underflows: phase exits are taken at timer_sec==1, never from 0.

Test Plan:
All scenarios use TICKS_PER_SEC=4.
1. Reset, then a start pulse -> phase=1, round_num=1, timer_sec=3, game_rst_l=0. 12 cycles later -> phase=2, timer_sec=99, game_rst_l=1.
2. In FIGHT, drive finish=01 -> next cycle phase=3, round_result=01, p1_wins=1. After 12 cycles -> phase=1, round_num=2.
3. P1 wins rounds 1 and 2 -> after ROUND_END, phase=4, match_winner=01. Start pulse -> phase=1, round_num=1, both win counts 0, match_winner=00.
4. Timeouts and draws:
   - Timeout with p1_health=7, p2_health=9 -> round_result=10, p2_wins+1.
   - Timeout with 5/5 -> round_result=11, no win increment.
   - Five straight draws -> phase=4, match_winner=11.
5. finish=11 on the same cycle as the final FIGHT tick -> round_result=10, not a timeout decision.
6. Mid-operation reset:
   - reset high during FIGHT -> next edge phase=0, game_rst_l=0, all counts 0.
   - start_btn held high across reset release -> phase stays 0 until the button is released and pressed again.
